// File: rtl/mips_imem_loader.sv
// Instruction-memory loader: accepts 32-bit words on a valid/ready stream and writes
// each one as four little-endian byte writes, holding the CPU while a load is in progress.
module mips_imem_loader #(
  parameter int MEM_BYTES = 128,
  parameter int BASE_ADDR = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] WORD_IN,
  input  logic        WORD_LAST,
  input  logic        WORD_VALID,
  output logic        WORD_READY,
  output logic        MEM_WE,
  output logic [31:0] MEM_WADDR,
  output logic [7:0]  MEM_WDATA,
  output logic        CPU_HOLD,
  output logic        DONE,
  output logic        OVERFLOW,
  output logic [31:0] BYTES_WRITTEN
);

  localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);
  localparam logic [31:0] BASE_ADDR_W = 32'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WORD,
    WRITE,
    DONE_S,
    ERROR_S
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic [31:0] bytes_q, bytes_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      bytes_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      last_q  <= last_d;
      bytes_q <= bytes_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    word_d  = word_q;
    last_d  = last_q;
    bytes_d = bytes_q;
    case (state_q)
      IDLE, DONE_S, ERROR_S: begin
        if (START) begin
          state_d = WAIT_WORD;
          ptr_d   = '0;
          bytes_d = '0;
        end
      end
      WAIT_WORD: begin
        if (WORD_VALID) begin
          word_d  = WORD_IN;
          last_d  = WORD_LAST;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        ptr_d   = ptr_q + 32'd1;
        bytes_d = bytes_q + 32'd1;
        idx_d   = idx_q + 2'd1;
        // LAST wins over a full memory: a program that exactly fills it is a clean load.
        if (idx_q == 2'd3) begin
          if (last_q) begin
            state_d = DONE_S;
          end else if (ptr_d == MEM_BYTES_W) begin
            state_d = ERROR_S;
          end else begin
            state_d = WAIT_WORD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign WORD_READY    = (state_q == WAIT_WORD);
  assign MEM_WE        = (state_q == WRITE);
  assign MEM_WADDR     = BASE_ADDR_W + ptr_q;
  assign MEM_WDATA     = MEM_WE ? 8'(word_q >> {idx_q, 3'b000}) : 8'h00;
  assign CPU_HOLD      = (state_q == WAIT_WORD) || (state_q == WRITE);
  assign DONE          = (state_q == DONE_S);
  assign OVERFLOW      = (state_q == ERROR_S);
  assign BYTES_WRITTEN = bytes_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Bench for mips_imem_loader: two instances (base 0 and base 64) share one stimulus
// stream and are compared every cycle against a byte-level reference model.
module tb_mips_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] word_in = '0;
  logic        wlast = 1'b0;
  logic        valid = 1'b0;

  logic        ready0, we0, hold0, done0, ovf0;
  logic [31:0] waddr0, bw0;
  logic [7:0]  wdata0;
  logic        ready1, we1, hold1, done1, ovf1;
  logic [31:0] waddr1, bw1;
  logic [7:0]  wdata1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mips_imem_loader dut0 (
    .CLK(clk), .RST(rst), .START(start), .WORD_IN(word_in), .WORD_LAST(wlast),
    .WORD_VALID(valid), .WORD_READY(ready0), .MEM_WE(we0), .MEM_WADDR(waddr0),
    .MEM_WDATA(wdata0), .CPU_HOLD(hold0), .DONE(done0), .OVERFLOW(ovf0),
    .BYTES_WRITTEN(bw0)
  );

  mips_imem_loader #(.MEM_BYTES(128), .BASE_ADDR(64)) dut1 (
    .CLK(clk), .RST(rst), .START(start), .WORD_IN(word_in), .WORD_LAST(wlast),
    .WORD_VALID(valid), .WORD_READY(ready1), .MEM_WE(we1), .MEM_WADDR(waddr1),
    .MEM_WDATA(wdata1), .CPU_HOLD(hold1), .DONE(done1), .OVERFLOW(ovf1),
    .BYTES_WRITTEN(bw1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: load activity tracked as a byte count, memory image as a byte array.
  localparam int M_IDLE = 0, M_WAIT = 1, M_WR = 2, M_DONE = 3, M_ERR = 4;
  localparam int MEMB = 128;
  int          m_mode = M_IDLE;
  int          m_n = 0;
  int          m_k = 0;
  logic [31:0] m_w = '0;
  logic        m_l = 1'b0;
  bit          m_ok = 1'b0;
  logic [7:0]  em [0:MEMB-1];
  logic [7:0]  cap0 [0:255];
  logic [7:0]  cap1 [0:255];
  int          last_wa0 = -1;
  int          first_wa0 = -1;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE;
      m_n    = 0;
      m_ok   = 1'b1;
    end else if (m_ok) begin
      case (m_mode)
        M_IDLE, M_DONE, M_ERR: if (start) begin m_mode = M_WAIT; m_n = 0; end
        M_WAIT: if (valid) begin m_w = word_in; m_l = wlast; m_k = 0; m_mode = M_WR; end
        M_WR: begin
          if (m_n < MEMB) em[m_n] = 8'((m_w >> (8 * m_k)) & 32'hFF);
          m_n++;
          m_k++;
          if (m_k == 4) begin
            if (m_l) m_mode = M_DONE;
            else if (m_n == MEMB) m_mode = M_ERR;
            else m_mode = M_WAIT;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("ready0", {31'b0, ready0}, {31'b0, m_mode == M_WAIT});
      chk("ready1", {31'b0, ready1}, {31'b0, m_mode == M_WAIT});
      chk("we0", {31'b0, we0}, {31'b0, m_mode == M_WR});
      chk("we1", {31'b0, we1}, {31'b0, m_mode == M_WR});
      chk("hold0", {31'b0, hold0}, {31'b0, m_mode == M_WAIT || m_mode == M_WR});
      chk("hold1", {31'b0, hold1}, {31'b0, m_mode == M_WAIT || m_mode == M_WR});
      chk("done0", {31'b0, done0}, {31'b0, m_mode == M_DONE});
      chk("done1", {31'b0, done1}, {31'b0, m_mode == M_DONE});
      chk("ovf0", {31'b0, ovf0}, {31'b0, m_mode == M_ERR});
      chk("ovf1", {31'b0, ovf1}, {31'b0, m_mode == M_ERR});
      chk("bytes0", bw0, 32'(m_n));
      chk("bytes1", bw1, 32'(m_n));
      if (m_mode == M_WR) begin
        chk("waddr0", waddr0, 32'(m_n));
        chk("waddr1", waddr1, 32'(64 + m_n));
        chk("wdata0", {24'b0, wdata0}, (m_w >> (8 * m_k)) & 32'hFF);
        chk("wdata1", {24'b0, wdata1}, (m_w >> (8 * m_k)) & 32'hFF);
      end
    end
    if (we0) begin
      cap0[waddr0[7:0]] = wdata0;
      last_wa0 = int'(waddr0);
      if (first_wa0 < 0) first_wa0 = int'(waddr0);
    end
    if (we1) cap1[waddr1[7:0]] = wdata1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    first_wa0 = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents a word and returns once the accepting edge has passed; valid stays high.
  task automatic send_word(input logic [31:0] w, input logic l, output int acc_cyc);
    int i;
    valid   = 1'b1;
    word_in = w;
    wlast   = l;
    acc_cyc = -1;
    for (i = 0; i < 40 && !ready0; i++) tick();
    if (!ready0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
    end else begin
      acc_cyc = cyc;
      tick();
    end
    word_in = $urandom;
    wlast   = 1'($urandom);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 200 && !(done0 || ovf0); i++) tick();
    chk("load_end", {31'b0, done0 | ovf0}, 32'd1);
  endtask

  int acc[4];
  int t;
  bit saw;

  initial begin
    for (int i = 0; i < 256; i++) begin cap0[i] = 8'h00; cap1[i] = 8'h00; end
    for (int i = 0; i < MEMB; i++) em[i] = 8'h00;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_we", {31'b0, we0}, 32'd0);
    chk("rst_waddr0", waddr0, 32'd0);
    chk("rst_waddr1", waddr1, 32'd64);
    chk("rst_wdata", {24'b0, wdata0}, 32'd0);
    chk("rst_ready", {31'b0, ready0}, 32'd0);
    chk("rst_hold", {31'b0, hold0}, 32'd0);
    chk("rst_bytes", bw0, 32'd0);

    // T1 two-word load
    start_load();
    send_word(32'h8C010004, 1'b0, t);
    send_word(32'h00221820, 1'b1, t);
    valid = 1'b0;
    wait_end();
    chk("t1_b0", {24'b0, cap0[0]}, 32'h04);
    chk("t1_b1", {24'b0, cap0[1]}, 32'h00);
    chk("t1_b2", {24'b0, cap0[2]}, 32'h01);
    chk("t1_b3", {24'b0, cap0[3]}, 32'h8C);
    chk("t1_b4", {24'b0, cap0[4]}, 32'h20);
    chk("t1_b5", {24'b0, cap0[5]}, 32'h18);
    chk("t1_b6", {24'b0, cap0[6]}, 32'h22);
    chk("t1_b7", {24'b0, cap0[7]}, 32'h00);
    chk("t1_done", {31'b0, done0}, 32'd1);
    chk("t1_bytes", bw0, 32'd8);
    chk("t1_hold", {31'b0, hold0}, 32'd0);

    // T5 base 64 instance
    start_load();
    send_word(32'hDEADBEEF, 1'b1, t);
    valid = 1'b0;
    wait_end();
    chk("t5_64", {24'b0, cap1[64]}, 32'hEF);
    chk("t5_65", {24'b0, cap1[65]}, 32'hBE);
    chk("t5_66", {24'b0, cap1[66]}, 32'hAD);
    chk("t5_67", {24'b0, cap1[67]}, 32'hDE);

    // T2 back-pressure: valid held high, one accept every 5 cycles
    start_load();
    for (int i = 0; i < 4; i++) send_word($urandom, 1'(i == 3), acc[i]);
    valid = 1'b0;
    wait_end();
    for (int i = 1; i < 4; i++) chk("t2_period", 32'(acc[i] - acc[i-1]), 32'd5);
    chk("t2_bytes", bw0, 32'd16);

    // T3 overflow
    start_load();
    for (int i = 0; i < 32; i++) send_word($urandom, 1'b0, t);
    word_in = $urandom;
    wlast = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ready0) saw = 1'b1;
    end
    valid = 1'b0;
    chk("t3_no_33rd", {31'b0, saw}, 32'd0);
    chk("t3_ovf", {31'b0, ovf0}, 32'd1);
    chk("t3_done", {31'b0, done0}, 32'd0);
    chk("t3_last_addr", 32'(last_wa0), 32'd127);
    chk("t3_bytes", bw0, 32'd128);

    // T4 reset during WRITE idx=1 of word 0
    start_load();
    send_word(32'h11223344, 1'b0, t);
    valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_we", {31'b0, we0}, 32'd0);
    chk("t4_hold", {31'b0, hold0}, 32'd0);
    chk("t4_done", {31'b0, done0}, 32'd0);
    chk("t4_ready", {31'b0, ready0}, 32'd0);
    start_load();
    send_word(32'hCAFEF00D, 1'b1, t);
    valid = 1'b0;
    wait_end();
    chk("t4_restart_addr", 32'(first_wa0), 32'd0);

    // T6 start in WAIT_WORD ignored; start after DONE restarts
    start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_still_wait", {31'b0, ready0}, 32'd1);
    send_word(32'h0BADC0DE, 1'b1, t);
    valid = 1'b0;
    wait_end();
    chk("t6_done", {31'b0, done0}, 32'd1);
    start_load();
    chk("t6_done_clr", {31'b0, done0}, 32'd0);
    chk("t6_bytes_clr", bw0, 32'd0);
    send_word(32'h12345678, 1'b1, t);
    valid = 1'b0;
    wait_end();
    chk("t6_restart_addr", 32'(first_wa0), 32'd0);

    // START with WORD_VALID in DONE: start acts, word accepted next cycle
    valid = 1'b1;
    word_in = 32'hA5A5A5A5;
    wlast = 1'b1;
    start_load();
    tick();
    valid = 1'b0;
    wait_end();

    // Randomized loads with gaps, ignored STARTs and occasional mid-load reset
    for (int ld = 0; ld < 30; ld++) begin
      int n, rs;
      n  = $urandom_range(1, 8);
      rs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      valid = 1'($urandom_range(0, 3) == 0);
      word_in = $urandom;
      start_load();
      for (int i = 0; i < n; i++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          valid = 1'b0;
          start = 1'($urandom_range(0, 3) == 0);
          word_in = $urandom;
          tick();
          start = 1'b0;
        end
        send_word($urandom, 1'(i == n - 1), t);
        if (i == rs) break;
      end
      valid = 1'b0;
      if (rs >= 0) begin
        for (int g = $urandom_range(0, 5); g > 0; g--) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rnd_rst_we", {31'b0, we0}, 32'd0);
      end else begin
        wait_end();
      end
      tick();
    end

    begin
      int bad0, bad1;
      bad0 = 0;
      bad1 = 0;
      for (int i = 0; i < MEMB; i++) begin
        if (cap0[i] !== em[i]) bad0++;
        if (cap1[64 + i] !== em[i]) bad1++;
      end
      chk("image0_bad_bytes", 32'(bad0), 32'd0);
      chk("image1_bad_bytes", 32'(bad1), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
